spi_mem_responder: RTL and testbench
====================================

SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

Interface
REQ-001 Parameter ADDR_BYTES, default 3: address bytes following each command byte, sent MSB first.
REQ-002 Parameter MEM_DEPTH, default 256: internal byte-array depth, a power of two.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI clock from the initiator, mode 0, asynchronous to clk.
REQ-006 cs_n  input  1  active-low chip select from the initiator, asynchronous to clk.
REQ-007 mosi  input  1  serial data from the initiator.
REQ-008 miso  output  1  serial data to the initiator.
REQ-009 miso_oe  output  1  high while miso is actively driven.
REQ-010 wr_pulse  output  1  one-clk strobe per committed write byte.
REQ-011 wr_addr  output  log2(MEM_DEPTH)  address of the committed byte, valid with wr_pulse.
REQ-012 wr_data  output  8  committed byte, valid with wr_pulse.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 sclk, cs_n and mosi SHALL each pass a 2-flop synchronizer; sclk edges SHALL be detected from a third flop.
REQ-015 Correct operation SHALL require a clk frequency of at least 8x sclk.
REQ-016 States SHALL be IDLE, CMD, ADDR, RD, WR and IGNORE; synchronized cs_n falling moves IDLE to CMD with a bit count of 0.
REQ-017 mosi SHALL be sampled on synchronized sclk rising edges, MSB first, with a 3-bit bit counter.
REQ-018 After 8 CMD bits: 0x03 -> ADDR, then RD; 0x02 -> ADDR, then WR; any other value -> IGNORE.
REQ-019 ADDR SHALL shift in 8*ADDR_BYTES bits; the address register SHALL keep the low log2(MEM_DEPTH) bits.
REQ-020 RD: the sclk falling edge after the final address bit SHALL load mem[addr] and drive bit 7 on miso; each later falling edge SHALL shift out the next bit.
REQ-021 RD: the falling edge after the 8th data bit SHALL increment addr and load the next byte, so reads stream sequentially.
REQ-022 WR: each completed 8-bit byte SHALL write mem[addr], pulse wr_pulse for exactly 1 clk with wr_addr/wr_data, and then increment addr.
REQ-023 Address increment SHALL wrap modulo MEM_DEPTH (MEM_DEPTH-1 -> 0).
REQ-024 miso_oe SHALL be 1 only in RD (and RDSR when enabled); otherwise miso = 0 and miso_oe = 0.
REQ-025 In IGNORE, further bits SHALL be discarded, memory left untouched, and miso held 0.
REQ-026 Synchronized cs_n rising in any state SHALL return the block to IDLE within 1 clk, discard any partial byte, and clear miso/miso_oe.
REQ-027 If a cs_n rise and a byte completion fall in the same clk, the completed byte SHALL commit first.

Reset
REQ-028 rst SHALL force IDLE, bit counter 0, address 0, shift registers 0, miso 0, miso_oe 0, wr_pulse 0, wr_addr 0, wr_data 0, busy 0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 A reset asserted mid-transaction SHALL abort it; the block SHALL resume only on the next cs_n falling edge seen after rst deasserts.

Configuration
REQ-031 Macro SPI_RESP_RDSR_EN defined: 0x05 (RDSR) SHALL stream the 8-bit status register (reset value 8'h40) repeatedly until cs_n rises; 0x01 (WRSR) SHALL load the next full byte into it.
REQ-032 Macro SPI_RESP_RDSR_EN undefined: 0x05 and 0x01 SHALL be treated as unknown commands (IGNORE), and no status register logic SHALL exist.

Verification
REQ-033 Write 0x02,00,00,10,AA,55, deassert, then read 0x03,00,00,10 for 16 clocks -> miso returns AA then 55; wr_pulse fires twice (addr 0x10/0x11).
REQ-034 Write 0x02,00,00,FF,11,22 -> mem[0xFF]=11 and mem[0x00]=22; a read from 0xFF returns 11,22.
REQ-035 Write 0x02,00,00,20,then 4 bits of 0xC3, then raise cs_n -> no wr_pulse; mem[0x20] unchanged; busy low within 3 clk.
REQ-036 Send 0x9F then 16 clocks -> miso_oe stays 0, miso 0, no wr_pulse.
REQ-037 Assert rst during the address phase, release it, then run a complete read from 0x10 -> correct data; all outputs are at reset values while rst is high.
REQ-038 With SPI_RESP_RDSR_EN: 0x05 -> 0x40 0x40; 0x01,0x00 then 0x05 -> 0x00. Without the macro: 0x05 -> miso_oe 0.

Source files
------------

// File: rtl/spi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_responder
// Purpose  : SPI mode-0 target emulating a small byte-addressed memory.
//            Commands: 0x03 read (streaming), 0x02 write (streaming).
//            Optional status register commands 0x05 (RDSR) / 0x01 (WRSR)
//            are built only when the macro SPI_RESP_RDSR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_responder #(
   parameter int ADDR_BYTES = 3,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         cs_n,
   input  logic                         mosi,
   output logic                         miso,
   output logic                         miso_oe,
   output logic                         wr_pulse,
   output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
   output logic [7:0]                   wr_data,
   output logic                         busy
);

   localparam int         C_AW        = $clog2(MEM_DEPTH);
   localparam int         C_ACW       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam logic [7:0] C_CMD_READ  = 8'h03;
   localparam logic [7:0] C_CMD_WRITE = 8'h02;
`ifdef SPI_RESP_RDSR_EN
   localparam logic [7:0] C_CMD_RDSR  = 8'h05;
   localparam logic [7:0] C_CMD_WRSR  = 8'h01;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_RD     = 3'd3,
      ST_WR     = 3'd4,
      ST_IGNORE = 3'd5
`ifdef SPI_RESP_RDSR_EN
      ,
      ST_RDSR   = 3'd6,
      ST_WRSR   = 3'd7
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_sclk_sync;
   logic [2:0]        r_cs_sync;
   logic [1:0]        r_mosi_sync;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_shift_in;
   logic [7:0]        r_shift_out;
   logic [C_AW-1:0]   r_addr;
   logic [C_ACW-1:0]  r_addr_cnt;
   logic              r_is_read;
   logic [7:0]        r_mem [0:MEM_DEPTH-1];

   logic              w_sclk_rise;
   logic              w_sclk_fall;
   logic              w_cs_fall;
   logic              w_cs_rise;
   logic [7:0]        w_byte;
   logic              w_byte_done;
   logic              w_addr_last;
   logic              w_tx_state;
   logic              w_wr_commit;
   logic [7:0]        w_load_byte;
   logic [C_AW-1:0]   w_addr_shift;

   // Edge detection on the synchronized copies; the third flop holds history.
   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
   assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
   assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];

   assign w_byte      = {r_shift_in[6:0], r_mosi_sync[1]};
   assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
   assign w_addr_last = (r_addr_cnt == C_ACW'(ADDR_BYTES - 1));
   assign w_wr_commit = (r_state == ST_WR) && w_byte_done;
   assign busy        = (r_state != ST_IDLE);

`ifdef SPI_RESP_RDSR_EN
   logic [7:0] r_status;
   assign w_tx_state  = (r_state == ST_RD) || (r_state == ST_RDSR);
   assign w_load_byte = (r_state == ST_RDSR) ? r_status : r_mem[r_addr];
`else
   assign w_tx_state  = (r_state == ST_RD);
   assign w_load_byte = r_mem[r_addr];
`endif

   // Address bytes arrive MSB first; only the low C_AW bits are retained.
   generate
      if (C_AW > 8) begin : g_addr_wide
         assign w_addr_shift = {r_addr[C_AW-9:0], w_byte};
      end else begin : g_addr_narrow
         assign w_addr_shift = w_byte[C_AW-1:0];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode; cs_n rising wins over everything outside IDLE.
   always_comb begin
      w_next = r_state;
      if (r_state == ST_IDLE) begin
         if (w_cs_fall) w_next = ST_CMD;
      end else if (w_cs_rise) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_CMD: begin
               if (w_byte_done) begin
                  case (w_byte)
                     C_CMD_READ, C_CMD_WRITE: w_next = ST_ADDR;
`ifdef SPI_RESP_RDSR_EN
                     C_CMD_RDSR:              w_next = ST_RDSR;
                     C_CMD_WRSR:              w_next = ST_WRSR;
`endif
                     default:                 w_next = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: begin
               if (w_byte_done && w_addr_last) w_next = r_is_read ? ST_RD : ST_WR;
            end
`ifdef SPI_RESP_RDSR_EN
            ST_WRSR: begin
               if (w_byte_done) w_next = ST_IGNORE;
            end
`endif
            default: w_next = r_state;
         endcase
      end
   end

   // Synchronizers, shift/count datapath, write strobe and miso driver.
   // cs_n history resets low so a chip select held low through reset
   // never looks like a fresh falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= 3'b000;
         r_cs_sync   <= 3'b000;
         r_mosi_sync <= 2'b00;
         r_bit_cnt   <= 3'd0;
         r_shift_in  <= 8'h00;
         r_shift_out <= 8'h00;
         r_addr      <= '0;
         r_addr_cnt  <= '0;
         r_is_read   <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         wr_pulse    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= 8'h00;
`ifdef SPI_RESP_RDSR_EN
         r_status    <= 8'h40;
`endif
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], sclk};
         r_cs_sync   <= {r_cs_sync[1:0], cs_n};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
         wr_pulse    <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_cs_fall) begin
               r_bit_cnt  <= 3'd0;
               r_shift_in <= 8'h00;
               r_addr_cnt <= '0;
            end
         end else if (!w_tx_state) begin
            if (w_sclk_rise) begin
               r_shift_in <= w_byte;
               r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if ((r_state == ST_CMD) && w_byte_done) r_is_read <= (w_byte == C_CMD_READ);
            if ((r_state == ST_ADDR) && w_byte_done) begin
               r_addr     <= w_addr_shift;
               r_addr_cnt <= r_addr_cnt + C_ACW'(1);
            end
            if (w_wr_commit) begin
               wr_pulse <= 1'b1;
               wr_addr  <= r_addr;
               wr_data  <= w_byte;
               r_addr   <= r_addr + C_AW'(1);
            end
`ifdef SPI_RESP_RDSR_EN
            if ((r_state == ST_WRSR) && w_byte_done) r_status <= w_byte;
`endif
         end else if (w_sclk_fall) begin
            // Bit count 0 marks a byte boundary: load the next byte. r_addr
            // always points at the byte to be loaded next.
            if (r_bit_cnt == 3'd0) begin
               miso        <= w_load_byte[7];
               r_shift_out <= {w_load_byte[6:0], 1'b0};
               miso_oe     <= 1'b1;
               if (r_state == ST_RD) r_addr <= r_addr + C_AW'(1);
            end else begin
               miso        <= r_shift_out[7];
               r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         // Deselect drops any partial byte; a byte completing this same
         // clk has already been committed above.
         if ((r_state != ST_IDLE) && w_cs_rise) begin
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 8'h00;
            r_shift_out <= 8'h00;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
         end
      end
   end

   // Memory array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_commit) r_mem[r_addr] <= w_byte;
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_mem_responder
// Purpose  : Self-checking bench for spi_mem_responder with a reference
//            memory model and write/read scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_responder;

   localparam int C_HALF = 8;   // clk cycles per half sclk period (16x ratio)

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic       wr_pulse;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] tb_mem [0:255];
   logic [7:0] rd_q [$];
   logic [15:0] wr_q [$];

   spi_mem_responder #(.ADDR_BYTES(3), .MEM_DEPTH(256)) dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .wr_pulse (wr_pulse),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Write scoreboard: every strobe must match the oldest expected commit.
   always @(negedge clk) begin
      if (wr_pulse === 1'b1) begin
         if (wr_q.size() == 0) check_value("wr_unexpected_pulse", {31'd0, wr_pulse}, 32'd0);
         else                  check_value("wr_commit", {16'd0, wr_addr, wr_data}, {16'd0, wr_q.pop_front()});
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b, output logic r, output logic oe);
      mosi = b;
      wait_clks(C_HALF);
      r  = miso;
      oe = miso_oe;
      sclk = 1'b1;
      wait_clks(C_HALF);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
      logic r, o;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r, o);
         rx[i] = r;
         oe[i] = o;
      end
   endtask

   task automatic send(input logic [7:0] tx);
      logic [7:0] rx, oe;
      spi_byte(tx, rx, oe);
   endtask

   task automatic cs_lo();
      cs_n = 1'b0;
      wait_clks(C_HALF);
   endtask

   task automatic cs_hi();
      wait_clks(C_HALF);
      cs_n = 1'b1;
      wait_clks(12);
   endtask

   task automatic do_write(input logic [7:0] a, input int n, input logic [15:0] d);
      logic [7:0] wa, wd;
      cs_lo();
      send(8'h02); send(8'h00); send(8'h00); send(a);
      for (int i = 0; i < n; i++) begin
         wa = a + 8'(i);
         wd = (i == 0) ? d[15:8] : d[7:0];
         tb_mem[wa] = wd;
         wr_q.push_back({wa, wd});
         send(wd);
      end
      cs_hi();
      check_value("wr_queue_drained", wr_q.size(), 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [7:0] a, input int n);
      logic [7:0] rx, oe, wa;
      cs_lo();
      send(8'h03); send(8'h00); send(8'h00); send(a);
      for (int i = 0; i < n; i++) begin
         wa = a + 8'(i);
         rd_q.push_back(tb_mem[wa]);
         spi_byte(8'h00, rx, oe);
         check_value(tag, rx, rd_q.pop_front());
         check_value({tag, "_oe"}, oe, 32'hFF);
      end
      cs_hi();
   endtask

   // Hard time limit so the bench can never hang.
   initial begin
      #5ms;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rx, oe;
      logic       r, o;
      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      wait_clks(5);
      check_value("rst_miso",    miso,     32'd0);
      check_value("rst_miso_oe", miso_oe,  32'd0);
      check_value("rst_wr_pulse",wr_pulse, 32'd0);
      check_value("rst_wr_addr", wr_addr,  32'd0);
      check_value("rst_wr_data", wr_data,  32'd0);
      check_value("rst_busy",    busy,     32'd0);
      rst = 1'b0;
      wait_clks(5);

      // Streaming write then read back.
      do_write(8'h10, 2, 16'hAA55);
      do_read("rd_10", 8'h10, 2);

      // Address wrap on write and on read.
      do_write(8'hFF, 2, 16'h1122);
      do_read("rd_wrap", 8'hFF, 2);

      // Partial byte aborted by deselect must not commit.
      do_write(8'h20, 1, 16'h5A00);
      cs_lo();
      send(8'h02); send(8'h00); send(8'h00); send(8'h20);
      spi_bit(1'b1, r, o); spi_bit(1'b1, r, o); spi_bit(1'b0, r, o); spi_bit(1'b0, r, o);
      wait_clks(C_HALF);
      cs_n = 1'b1;
      wait_clks(3);
      check_value("abort_busy", busy, 32'd0);
      wait_clks(12);
      check_value("abort_no_commit", wr_q.size(), 32'd0);
      do_read("rd_20", 8'h20, 1);

      // Unknown command: bus stays quiet.
      cs_lo();
      send(8'h9F);
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'hFF, rx, oe);
         check_value("ign_miso", rx, 32'd0);
         check_value("ign_oe",   oe, 32'd0);
      end
      cs_hi();

      // Reset in the middle of an address phase.
      cs_lo();
      send(8'h03); send(8'h00);
      spi_bit(1'b0, r, o); spi_bit(1'b0, r, o);
      rst = 1'b1;
      wait_clks(3);
      check_value("mid_rst_miso",    miso,     32'd0);
      check_value("mid_rst_miso_oe", miso_oe,  32'd0);
      check_value("mid_rst_wr_pulse",wr_pulse, 32'd0);
      check_value("mid_rst_wr_addr", wr_addr,  32'd0);
      check_value("mid_rst_wr_data", wr_data,  32'd0);
      check_value("mid_rst_busy",    busy,     32'd0);
      rst = 1'b0;
      wait_clks(4);
      cs_n = 1'b1;
      wait_clks(12);
      do_read("rd_after_rst", 8'h10, 2);

`ifdef SPI_RESP_RDSR_EN
      cs_lo();
      send(8'h05);
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'h00, rx, oe);
         check_value("rdsr_reset_val", rx, 32'h40);
         check_value("rdsr_oe",        oe, 32'hFF);
      end
      cs_hi();
      cs_lo(); send(8'h01); send(8'h00); cs_hi();
      cs_lo();
      send(8'h05);
      spi_byte(8'h00, rx, oe);
      check_value("rdsr_after_wrsr", rx, 32'h00);
      check_value("rdsr2_oe",        oe, 32'hFF);
      cs_hi();
`else
      cs_lo();
      send(8'h05);
      spi_byte(8'h00, rx, oe);
      check_value("rdsr_off_oe",   oe, 32'd0);
      check_value("rdsr_off_miso", rx, 32'd0);
      cs_hi();
`endif

      check_value("final_wr_queue", wr_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
